// File: rtl/serial_bus_mux_if.sv
// serial_bus_mux_if: N-master serial bus signals (m_* per-master side, s_* shared link, owner_o/busy_o status); slave=mux view, master=driver view
interface serial_bus_mux_if #(
  parameter int NUM_MASTERS = 4,
  parameter int LANES = 1
);
  logic [NUM_MASTERS-1:0] m_req_i, m_gnt_o, m_sclk_i, m_svalid_i, m_sready_o;
  logic [NUM_MASTERS-1:0] m_resp_sclk_o, m_resp_svalid_o, m_timeout_o;
  logic [NUM_MASTERS*LANES-1:0] m_sdata_i, m_resp_sdata_o;
  logic [LANES-1:0] s_sdata_o, s_resp_sdata_i;
  logic s_sclk_o, s_svalid_o, s_sready_i, s_resp_sclk_i, s_resp_svalid_i, busy_o;
  logic [$clog2(NUM_MASTERS)-1:0] owner_o;
  modport slave (
    input  m_req_i, m_sdata_i, m_sclk_i, m_svalid_i, s_sready_i, s_resp_sdata_i, s_resp_sclk_i, s_resp_svalid_i,
    output m_gnt_o, m_sready_o, m_resp_sdata_o, m_resp_sclk_o, m_resp_svalid_o, m_timeout_o,
           s_sdata_o, s_sclk_o, s_svalid_o, owner_o, busy_o
  );
  modport master (
    output m_req_i, m_sdata_i, m_sclk_i, m_svalid_i, s_sready_i, s_resp_sdata_i, s_resp_sclk_i, s_resp_svalid_i,
    input  m_gnt_o, m_sready_o, m_resp_sdata_o, m_resp_sclk_o, m_resp_svalid_o, m_timeout_o,
           s_sdata_o, s_sclk_o, s_svalid_o, owner_o, busy_o
  );
endinterface

// File: rtl/serial_bus_mux.sv
// serial_bus_mux: round-robin N-master frame-locked serial link mux with watchdog and turnaround gap; ports clk_i, rst_i, bus (serial_bus_mux_if.slave)
module serial_bus_mux #(
  parameter int NUM_MASTERS = 4,
  parameter int LANES = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int IDLE_GAP = 1
) (
  input logic clk_i,
  input logic rst_i,
  serial_bus_mux_if.slave bus
);
  localparam int OW = $clog2(NUM_MASTERS);
  localparam int TMAX = TIMEOUT_CYCLES > IDLE_GAP ? TIMEOUT_CYCLES : IDLE_GAP;
  localparam int TW = $clog2(TMAX + 2);
  typedef enum logic [2:0] {IDLE, GRANT, REQ, RESP, GAP} state_t;
  localparam state_t AFTER = IDLE_GAP == 0 ? IDLE : GAP;
  state_t state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, win, idx;
  logic [TW-1:0] timer_q, timer_d;
  logic [NUM_MASTERS-1:0] timeout_q, timeout_d, own_oh;
  logic [LANES-1:0] sdata;
  logic flag_q, flag_d, found, fwd_req, fwd_resp, wd_hit;
  assign own_oh = NUM_MASTERS'(1) << owner_q;
  assign fwd_req = state_q == GRANT || state_q == REQ;
  assign fwd_resp = state_q == REQ || state_q == RESP;
  assign wd_hit = TIMEOUT_CYCLES > 0 && timer_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    win = rr_q;
    idx = rr_q;
    found = 1'b0;
    sdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = OW'((int'(rr_q) + i) % NUM_MASTERS);
      if (!found && bus.m_req_i[idx]) begin
        found = 1'b1;
        win = idx;
      end
      if (owner_q == OW'(i)) sdata = bus.m_sdata_i[i*LANES +: LANES];
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    timeout_d = '0;
    flag_d = state_q == RESP && (flag_q || bus.s_resp_svalid_i);
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        owner_d = win;
        rr_d = OW'((int'(win) + 1) % NUM_MASTERS);
      end
      GRANT: state_d = bus.m_svalid_i[owner_q] ? REQ : !bus.m_req_i[owner_q] ? AFTER : GRANT;
      REQ: state_d = bus.m_svalid_i[owner_q] ? REQ : RESP;
      RESP: state_d = flag_q && !bus.s_resp_svalid_i ? AFTER : RESP;
      GAP: state_d = timer_q == TW'(IDLE_GAP - 1) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
    // watchdog only fires when no legal transition is taken this cycle
    if (state_d == state_q && (state_q == GRANT || fwd_resp) && wd_hit) begin
      state_d = AFTER;
      timeout_d = own_oh;
    end
    timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      timer_q <= '0;
      flag_q <= 1'b0;
      timeout_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      timer_q <= timer_d;
      flag_q <= flag_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.m_gnt_o = (state_q == GRANT || fwd_resp) ? own_oh : '0;
  assign bus.m_timeout_o = timeout_q;
  assign bus.owner_o = owner_q;
  assign bus.busy_o = state_q != IDLE;
  assign bus.s_sdata_o = fwd_req ? sdata : '0;
  assign bus.s_sclk_o = fwd_req && bus.m_sclk_i[owner_q];
  assign bus.s_svalid_o = fwd_req && bus.m_svalid_i[owner_q];
  assign bus.m_sready_o = fwd_req ? own_oh & {NUM_MASTERS{bus.s_sready_i}} : '0;
  assign bus.m_resp_sclk_o = fwd_resp ? own_oh & {NUM_MASTERS{bus.s_resp_sclk_i}} : '0;
  assign bus.m_resp_svalid_o = fwd_resp ? own_oh & {NUM_MASTERS{bus.s_resp_svalid_i}} : '0;
  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_resp
    assign bus.m_resp_sdata_o[k*LANES +: LANES] = (fwd_resp && owner_q == OW'(k)) ? bus.s_resp_sdata_i : '0;
  end
endmodule

// File: tb/tb_serial_bus_mux.sv
// tb_serial_bus_mux: randomized self-checking bench for serial_bus_mux against a frame-level reference model
module tb_serial_bus_mux;
  localparam int N = 4;
  localparam int L = 2;
  localparam int TO = 64;
  localparam int G = 3;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int checks = 0;
  int failures = 0;
  int m_rr = 0;
  always #5 clk_i = ~clk_i;
  serial_bus_mux_if #(.NUM_MASTERS(N), .LANES(L)) bus ();
  serial_bus_mux #(.NUM_MASTERS(N), .LANES(L), .TIMEOUT_CYCLES(TO), .IDLE_GAP(G)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );
  function automatic int pick(input logic [N-1:0] req, input int rr);
    for (int i = 0; i < N; i++) if (req[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] oh(input int k);
    return N'(1) << k;
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic clear();
    bus.m_req_i = '0;
    bus.m_sdata_i = '0;
    bus.m_sclk_i = '0;
    bus.m_svalid_i = '0;
    bus.s_sready_i = 1'b0;
    bus.s_resp_sdata_i = '0;
    bus.s_resp_sclk_i = 1'b0;
    bus.s_resp_svalid_i = 1'b0;
  endtask
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask
  task automatic run_frame(input int k, input int nreq, input int nresp);
    for (int i = 0; i < nreq; i++) begin
      bus.m_svalid_i[k] = 1'b1;
      bus.m_sdata_i[k*L +: L] = L'($urandom);
      bus.m_sclk_i[k] = i[0];
      tick();
    end
    bus.m_svalid_i[k] = 1'b0;
    bus.m_sclk_i[k] = 1'b0;
    tick();
    for (int i = 0; i < nresp; i++) begin
      bus.s_resp_svalid_i = 1'b1;
      bus.s_resp_sdata_i = L'($urandom);
      bus.s_resp_sclk_i = i[0];
      tick();
    end
    bus.s_resp_svalid_i = 1'b0;
    bus.s_resp_sclk_i = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    clear();
    bus.m_req_i = '1;
    bus.m_svalid_i = '1;
    bus.m_sdata_i = '1;
    bus.m_sclk_i = '1;
    bus.s_sready_i = 1'b1;
    bus.s_resp_svalid_i = 1'b1;
    bus.s_resp_sclk_i = 1'b1;
    bus.s_resp_sdata_i = '1;
    tick();
    tick();
    checks++; if (bus.m_gnt_o !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", bus.m_gnt_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.owner_o !== '0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", bus.owner_o); end
    checks++; if (bus.m_timeout_o !== '0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", bus.m_timeout_o); end
    checks++; if ({bus.s_svalid_o, bus.s_sclk_o, bus.s_sdata_o} !== '0) begin failures++; $display("FAIL reset_link got=%b exp=0", {bus.s_svalid_o, bus.s_sclk_o, bus.s_sdata_o}); end
    checks++; if ({bus.m_sready_o, bus.m_resp_svalid_o, bus.m_resp_sclk_o, bus.m_resp_sdata_o} !== '0) begin failures++; $display("FAIL reset_mresp got=%h exp=0", {bus.m_sready_o, bus.m_resp_svalid_o, bus.m_resp_sclk_o, bus.m_resp_sdata_o}); end
    clear();
    rst_i = 1'b0;
    m_rr = 0;
    tick();
  endtask
  task automatic test_round_robin();
    int exp;
    bit ok;
    for (int f = 0; f < 5; f++) begin
      bus.m_req_i = '1;
      exp = pick('1, m_rr);
      tick();
      checks++; if (bus.m_gnt_o !== oh(exp)) begin failures++; $display("FAIL rr_gnt frame=%0d got=%b exp=%b", f, bus.m_gnt_o, oh(exp)); end
      checks++; if (int'(bus.owner_o) != exp) begin failures++; $display("FAIL rr_owner frame=%0d got=%0d exp=%0d", f, bus.owner_o, exp); end
      checks++; if (exp != f % N) begin failures++; $display("FAIL rr_order frame=%0d got=%0d exp=%0d", f, exp, f % N); end
      m_rr = (exp + 1) % N;
      if (f == 4) bus.m_req_i = '0;
      run_frame(exp, 3, 2);
      wait_idle(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_idle frame=%0d got=busy exp=idle", f); end
    end
  endtask
  task automatic test_forwarding();
    logic [N*L-1:0] all_d, exp_r;
    logic [N-1:0] all_sclk, all_sv;
    logic [L-1:0] rdat;
    logic rdy, rsclk;
    int exp;
    bit ok;
    bus.m_req_i = 4'b0100;
    exp = pick(4'b0100, m_rr);
    tick();
    checks++; if (bus.m_gnt_o !== oh(exp) || exp != 2) begin failures++; $display("FAIL fwd_gnt got=%b exp=%b", bus.m_gnt_o, oh(2)); end
    m_rr = (exp + 1) % N;
    for (int b = 0; b < 40; b++) begin
      all_d = N*L'($urandom);
      all_sclk = N'($urandom);
      all_sv = N'($urandom) | oh(2);
      rdat = L'($urandom);
      rdy = 1'($urandom);
      bus.m_sdata_i = all_d;
      bus.m_sclk_i = all_sclk;
      bus.m_svalid_i = all_sv;
      bus.s_sready_i = rdy;
      bus.s_resp_sdata_i = rdat;
      #1;
      exp_r = (b > 0) ? (N*L)'(rdat) << (2 * L) : '0;
      checks++; if (bus.s_sdata_o !== all_d[2*L +: L]) begin failures++; $display("FAIL fwd_sdata beat=%0d got=%b exp=%b", b, bus.s_sdata_o, all_d[2*L +: L]); end
      checks++; if (bus.s_sclk_o !== all_sclk[2] || bus.s_svalid_o !== 1'b1) begin failures++; $display("FAIL fwd_sclk_svalid beat=%0d got=%b%b exp=%b1", b, bus.s_sclk_o, bus.s_svalid_o, all_sclk[2]); end
      checks++; if (bus.m_sready_o !== (rdy ? oh(2) : N'(0))) begin failures++; $display("FAIL fwd_sready beat=%0d got=%b exp=%b", b, bus.m_sready_o, rdy ? oh(2) : N'(0)); end
      checks++; if (bus.m_resp_sdata_o !== exp_r) begin failures++; $display("FAIL fwd_req_resp beat=%0d got=%b exp=%b", b, bus.m_resp_sdata_o, exp_r); end
      if (b == 0) bus.m_req_i = '0;
      tick();
    end
    bus.m_svalid_i = '0;
    tick();
    for (int b = 0; b < 20; b++) begin
      rdat = L'($urandom);
      rsclk = b[0];
      all_sv = N'($urandom) & ~oh(2);
      bus.m_svalid_i = all_sv;
      bus.m_sdata_i = N*L'($urandom);
      bus.m_sclk_i = '1;
      bus.s_sready_i = 1'b1;
      bus.s_resp_svalid_i = 1'b1;
      bus.s_resp_sdata_i = rdat;
      bus.s_resp_sclk_i = rsclk;
      #1;
      exp_r = (N*L)'(rdat) << (2 * L);
      checks++; if (bus.m_resp_sdata_o !== exp_r) begin failures++; $display("FAIL resp_sdata beat=%0d got=%b exp=%b", b, bus.m_resp_sdata_o, exp_r); end
      checks++; if (bus.m_resp_svalid_o !== oh(2) || bus.m_resp_sclk_o !== (rsclk ? oh(2) : N'(0))) begin failures++; $display("FAIL resp_ctl beat=%0d got=%b/%b", b, bus.m_resp_svalid_o, bus.m_resp_sclk_o); end
      checks++; if ({bus.s_svalid_o, bus.s_sclk_o, bus.s_sdata_o, bus.m_sready_o} !== '0) begin failures++; $display("FAIL resp_link_gated beat=%0d got=%b exp=0", b, {bus.s_svalid_o, bus.s_sclk_o, bus.s_sdata_o, bus.m_sready_o}); end
      tick();
    end
    bus.s_resp_svalid_i = 1'b0;
    #1;
    checks++; if (bus.m_resp_svalid_o !== '0 || bus.m_gnt_o !== oh(2)) begin failures++; $display("FAIL resp_end got=%b/%b exp=0/%b", bus.m_resp_svalid_o, bus.m_gnt_o, oh(2)); end
    tick();
    checks++; if (bus.m_gnt_o !== '0 || bus.busy_o !== 1'b1) begin failures++; $display("FAIL resp_to_gap got=%b/%b exp=0/1", bus.m_gnt_o, bus.busy_o); end
    clear();
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL fwd_idle got=busy exp=idle"); end
  endtask
  task automatic test_back_to_back();
    int exp, low, gap;
    bit ok;
    bus.m_req_i = 4'b0001;
    exp = pick(4'b0001, m_rr);
    tick();
    checks++; if (bus.m_gnt_o !== oh(exp)) begin failures++; $display("FAIL b2b_gnt0 got=%b exp=%b", bus.m_gnt_o, oh(exp)); end
    m_rr = (exp + 1) % N;
    bus.m_req_i = 4'b0010;
    run_frame(0, 4, 3);
    low = 0;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.m_gnt_o !== '0) break;
      low++;
      if (bus.busy_o) gap++;
      tick();
    end
    checks++; if (gap != G) begin failures++; $display("FAIL b2b_gap_cycles got=%0d exp=%0d", gap, G); end
    checks++; if (low != G + 1) begin failures++; $display("FAIL b2b_gnt_low got=%0d exp=%0d", low, G + 1); end
    exp = pick(4'b0010, m_rr);
    checks++; if (bus.m_gnt_o !== oh(exp)) begin failures++; $display("FAIL b2b_gnt1 got=%b exp=%b", bus.m_gnt_o, oh(exp)); end
    m_rr = (exp + 1) % N;
    bus.m_req_i = '0;
    run_frame(exp, 2, 1);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_idle got=busy exp=idle"); end
  endtask
  task automatic test_timeout();
    int w, other, exp;
    bit ok;
    w = m_rr;
    other = (w + 2) % N;
    bus.m_req_i = oh(w);
    tick();
    checks++; if (bus.m_gnt_o !== oh(w)) begin failures++; $display("FAIL to_gnt got=%b exp=%b", bus.m_gnt_o, oh(w)); end
    m_rr = (w + 1) % N;
    bus.m_req_i = oh(other);
    bus.m_svalid_i = oh(w);
    tick();
    for (int c = 1; c <= TO; c++) begin
      tick();
      if (c < TO) begin
        checks++; if (bus.m_timeout_o !== '0) begin failures++; $display("FAIL to_early cycle=%0d got=%b exp=0", c, bus.m_timeout_o); end
      end else begin
        checks++; if (bus.m_timeout_o !== oh(w)) begin failures++; $display("FAIL to_pulse cycle=%0d got=%b exp=%b", c, bus.m_timeout_o, oh(w)); end
        checks++; if (bus.m_gnt_o !== '0 || bus.busy_o !== 1'b1 || bus.s_svalid_o !== 1'b0) begin failures++; $display("FAIL to_abort got=%b/%b/%b exp=0/1/0", bus.m_gnt_o, bus.busy_o, bus.s_svalid_o); end
      end
    end
    tick();
    checks++; if (bus.m_timeout_o !== '0) begin failures++; $display("FAIL to_one_cycle got=%b exp=0", bus.m_timeout_o); end
    bus.m_svalid_i = '0;
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_idle got=busy exp=idle"); end
    exp = pick(oh(other), m_rr);
    tick();
    checks++; if (bus.m_gnt_o !== oh(exp) || exp != other) begin failures++; $display("FAIL to_next_gnt got=%b exp=%b", bus.m_gnt_o, oh(other)); end
    m_rr = (exp + 1) % N;
    bus.m_req_i = '0;
    run_frame(exp, 2, 1);
    wait_idle(ok);
  endtask
  task automatic test_withdraw();
    int exp;
    bit ok;
    bus.m_req_i = 4'b0010;
    exp = pick(4'b0010, m_rr);
    tick();
    checks++; if (bus.m_gnt_o !== oh(1) || int'(bus.owner_o) != exp) begin failures++; $display("FAIL wd_gnt got=%b/%0d exp=%b/%0d", bus.m_gnt_o, bus.owner_o, oh(1), exp); end
    m_rr = (exp + 1) % N;
    bus.m_req_i = '0;
    tick();
    checks++; if (bus.m_gnt_o !== '0 || bus.busy_o !== 1'b1 || bus.m_timeout_o !== '0) begin failures++; $display("FAIL wd_gap got=%b/%b/%b exp=0/1/0", bus.m_gnt_o, bus.busy_o, bus.m_timeout_o); end
    wait_idle(ok);
    checks++; if (!ok || bus.m_timeout_o !== '0) begin failures++; $display("FAIL wd_idle got=%0d/%b exp=1/0", ok, bus.m_timeout_o); end
    bus.m_req_i = '1;
    exp = pick('1, m_rr);
    tick();
    checks++; if (bus.m_gnt_o !== oh(exp) || exp != 2) begin failures++; $display("FAIL wd_next got=%b exp=%b", bus.m_gnt_o, oh(2)); end
    m_rr = (exp + 1) % N;
    bus.m_req_i = '0;
    run_frame(exp, 2, 1);
    wait_idle(ok);
  endtask
  task automatic test_reset_mid();
    int exp;
    bit ok;
    bus.m_req_i = 4'b1000;
    exp = pick(4'b1000, m_rr);
    tick();
    checks++; if (bus.m_gnt_o !== oh(3)) begin failures++; $display("FAIL rm_gnt got=%b exp=%b", bus.m_gnt_o, oh(3)); end
    m_rr = (exp + 1) % N;
    bus.m_req_i = '0;
    bus.m_svalid_i = oh(3);
    tick();
    tick();
    bus.m_svalid_i = '0;
    tick();
    bus.s_resp_svalid_i = 1'b1;
    tick();
    checks++; if (bus.m_resp_svalid_o !== oh(3)) begin failures++; $display("FAIL rm_in_resp got=%b exp=%b", bus.m_resp_svalid_o, oh(3)); end
    rst_i = 1'b1;
    tick();
    checks++; if (bus.m_gnt_o !== '0 || bus.busy_o !== 1'b0 || bus.owner_o !== '0 || bus.m_timeout_o !== '0) begin failures++; $display("FAIL rm_reset got=%b/%b/%0d/%b exp=0/0/0/0", bus.m_gnt_o, bus.busy_o, bus.owner_o, bus.m_timeout_o); end
    m_rr = 0;
    rst_i = 1'b0;
    clear();
    bus.m_req_i = '1;
    exp = pick('1, m_rr);
    tick();
    checks++; if (bus.m_gnt_o !== oh(exp) || int'(bus.owner_o) != 0) begin failures++; $display("FAIL rm_regrant got=%b/%0d exp=%b/0", bus.m_gnt_o, bus.owner_o, oh(exp)); end
    m_rr = (exp + 1) % N;
    bus.m_req_i = '0;
    run_frame(exp, 2, 1);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rm_idle got=busy exp=idle"); end
  endtask
  initial begin
    #2000000;
    $display("FAIL sim_timeout checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end
  initial begin
    clear();
    test_reset();
    test_round_robin();
    test_forwarding();
    test_back_to_back();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_bus_mux.md
Name: serial_bus_mux

Overview:
Parametrised N-master front-end for the bit-serial bus. It arbitrates NUM_MASTERS requesters round-robin and locks the grant for a whole frame. While locked it forwards the owner's LANES-wide serial request onto the single shared serial link and routes the serial response back to the owner only. A per-frame watchdog and a configurable inter-frame turnaround gap are included. It generalises the fixed 2-master, 1-lane mux/arbiter pairing, sitting between the per-master parallel_to_serial encoders and the shared serial_to_parallel decoder.

Parameters:
NUM_MASTERS, 4, number of requesting masters (>=2)
LANES, 1, serial data bits per sclk beat (request and response)
TIMEOUT_CYCLES, 64, max cycles spent in any one locked state before abort; 0 disables the watchdog
IDLE_GAP, 1, turnaround cycles after a frame before the next grant (0 allowed)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m_req_i  in  NUM_MASTERS  per-master bus request
m_gnt_o  out  NUM_MASTERS  one-hot grant, held for the whole frame
m_sdata_i  in  NUM_MASTERS*LANES  per-master serial request data, master k at [k*LANES +: LANES]
m_sclk_i  in  NUM_MASTERS  per-master request serial clock
m_svalid_i  in  NUM_MASTERS  per-master request frame valid
m_sready_o  out  NUM_MASTERS  link ready, owner only
m_resp_sdata_o  out  NUM_MASTERS*LANES  response data, owner only
m_resp_sclk_o  out  NUM_MASTERS  response serial clock, owner only
m_resp_svalid_o  out  NUM_MASTERS  response frame valid, owner only
m_timeout_o  out  NUM_MASTERS  one-cycle abort pulse to the owner
s_sdata_o  out  LANES  shared link request data
s_sclk_o  out  1  shared link request clock
s_svalid_o  out  1  shared link request valid
s_sready_i  in  1  shared link ready
s_resp_sdata_i  in  LANES  shared link response data
s_resp_sclk_i  in  1  shared link response clock
s_resp_svalid_i  in  1  shared link response valid
owner_o  out  $clog2(NUM_MASTERS)  index of current or last owner
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge): state=IDLE; rr pointer=0; owner_o=0; m_gnt_o=0; m_timeout_o=0; timer=0.
  - All forwarded outputs are 0 because they are gated by state.
  - Reset mid-frame aborts silently with no timeout pulse.
- FSM states: IDLE, GRANT, REQ, RESP, GAP.
- IDLE:
  - If any m_req_i bit is set, pick the first requester at or after the rr pointer, searching upward and wrapping.
  - Next cycle: owner_o = winner; m_gnt_o = onehot(winner); rr pointer = (winner+1) mod NUM_MASTERS; state -> GRANT.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT:
  - owner m_svalid_i=1 -> REQ.
  - Else if owner m_req_i=0 -> GAP (request withdrawn, no frame sent).
- REQ: owner m_svalid_i falls to 0 -> RESP.
- RESP:
  - An internal flag sets when s_resp_svalid_i=1.
  - When the flag is set and s_resp_svalid_i=0, go to GAP; if IDLE_GAP=0, go straight to IDLE.
  - The flag clears on entry to RESP.
- GAP: m_gnt_o=0. Stay IDLE_GAP cycles, then -> IDLE. Requests are not sampled during GAP.
- m_gnt_o is held high from the GRANT entry edge through the last RESP cycle.
- Forwarding is combinational, with zero added latency:
  - In GRANT or REQ: s_sdata_o, s_sclk_o and s_svalid_o equal the owner's inputs; m_sready_o[owner] = s_sready_i.
  - In every other state these outputs are 0.
  - In REQ or RESP: m_resp_*[owner] equal s_resp_* inputs.
  - Non-owners' m_sready_o and m_resp_* are 0 at all times.
- Watchdog:
  - The timer clears on every state transition and increments each cycle in GRANT, REQ and RESP.
  - If TIMEOUT_CYCLES>0 and the timer reaches TIMEOUT_CYCLES-1 without a transition, the next edge pulses m_timeout_o[owner] for 1 cycle, drops m_gnt_o, and goes to GAP (or IDLE if IDLE_GAP=0).
  - A legal transition and a timeout on the same cycle: the legal transition wins.
- A master deasserting m_req_i during REQ or RESP is ignored; the frame completes.
- owner_o holds its value through GAP and IDLE until the next grant.

Test Plan:
- NUM_MASTERS=4: m_req_i=4'b1111 held for 4 frames -> grants 0,1,2,3 in order, each m_gnt_o 1 cycle after IDLE; frame 5 is granted to 0 again.
- Master 2 sends a 40-beat LANES=2 frame; inject a response of 20 beats -> s_sdata_o matches m_sdata_i[5:4] on every beat; m_resp_sdata_o[5:4] matches the response; all other masters see 0.
- IDLE_GAP=3: back-to-back requests from masters 0 and 1 -> exactly 3 GAP cycles with m_gnt_o=0 between master 0's response end and master 1's grant.
- TIMEOUT_CYCLES=16: owner holds m_svalid_i=1 indefinitely -> m_timeout_o[owner] pulses for one cycle 16 cycles after REQ entry; grant drops; the next requester is served.
- Master 1 granted, then drops m_req_i with no svalid -> GRANT->GAP; no timeout pulse; the pointer advances to 2.
- Assert rst_i during RESP of master 3's frame -> next edge: m_gnt_o=0, busy_o=0, owner_o=0; with all masters requesting, the next grant goes to master 0.
